// File: rtl/minirisc_pkg.sv
// Shared KGP-miniRISC decode definitions: opcodes, class bit positions and the decoded record.
// The DECODE_ILLEGAL_CHECK_EN macro controls whether the illegal flag is ever set.
package minirisc_pkg;

    // Decoded records carry the widest supported datapath; users slice down to their own XLEN.
    localparam int XLEN_MAX = 64;

    localparam logic [5:0] OP_ALU_REG     = 6'b000000;
    localparam logic [5:0] OP_ALU_IMM     = 6'b000001;
    localparam logic [5:0] OP_LOAD        = 6'b000010;
    localparam logic [5:0] OP_STORE       = 6'b000011;
    localparam logic [5:0] OP_BRANCH      = 6'b000100;
    localparam logic [5:0] OP_BRANCH_COND = 6'b000101;
    localparam logic [5:0] OP_JUMP_REG    = 6'b000110;
    localparam logic [5:0] OP_SYS         = 6'b000111;

    localparam int CLS_ALU_REG     = 0;
    localparam int CLS_ALU_IMM     = 1;
    localparam int CLS_LOAD        = 2;
    localparam int CLS_STORE       = 3;
    localparam int CLS_BRANCH      = 4;
    localparam int CLS_BRANCH_COND = 5;
    localparam int CLS_JUMP_REG    = 6;
    localparam int CLS_SYS         = 7;

    localparam logic [5:0] FUNC_LIMIT = 6'd10;

    typedef struct packed {
        logic [5:0]          opcode;
        logic [5:0]          func;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] label0;
        logic [XLEN_MAX-1:0] label1;
        logic [7:0]          cls;
        logic                illegal;
        logic [XLEN_MAX-1:0] pc;
    } decoded_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field split, classification and sign extension of one instruction word.
// Illegal detection only exists when DECODE_ILLEGAL_CHECK_EN is defined.
module instr_field_decode
    import minirisc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output decoded_t        dec_o
);

    logic [5:0] opcode;
    logic [5:0] func;

    assign opcode = instr_i[31:26];
    assign func   = instr_i[5:0];

    always_comb begin
        dec_o         = '0;
        dec_o.opcode  = opcode;
        dec_o.func    = func;
        dec_o.rs      = instr_i[25:21];
        dec_o.rt      = instr_i[20:16];
        dec_o.imm     = {{(XLEN_MAX-16){instr_i[15]}}, instr_i[15:0]};
        dec_o.label0  = {{(XLEN_MAX-26){instr_i[25]}}, instr_i[25:0]};
        dec_o.label1  = {{(XLEN_MAX-21){instr_i[20]}}, instr_i[20:0]};
        dec_o.pc      = XLEN_MAX'(pc_i);

        case (opcode)
            OP_ALU_REG:     dec_o.cls[CLS_ALU_REG]     = 1'b1;
            OP_ALU_IMM:     dec_o.cls[CLS_ALU_IMM]     = 1'b1;
            OP_LOAD:        dec_o.cls[CLS_LOAD]        = 1'b1;
            OP_STORE:       dec_o.cls[CLS_STORE]       = 1'b1;
            OP_BRANCH:      dec_o.cls[CLS_BRANCH]      = 1'b1;
            OP_BRANCH_COND: dec_o.cls[CLS_BRANCH_COND] = 1'b1;
            OP_JUMP_REG:    dec_o.cls[CLS_JUMP_REG]    = 1'b1;
            OP_SYS:         dec_o.cls[CLS_SYS]         = 1'b1;
            default:        dec_o.cls                  = '0;
        endcase

`ifdef DECODE_ILLEGAL_CHECK_EN
        // An out-of-range ALU func keeps its ALU class so the consumer can still route it.
        dec_o.illegal = (opcode > OP_SYS) || ((opcode == OP_ALU_REG) && (func >= FUNC_LIMIT));
`endif
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Buffered decode stage: decodes on push and queues records in a DEPTH-entry FIFO with flush.
// DECODE_ILLEGAL_CHECK_EN enables out_illegal and the saturating illegal_cnt counter.
module instr_decode_queue
    import minirisc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               out_opcode,
    output logic [5:0]               out_func,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [XLEN-1:0]          out_imm,
    output logic [XLEN-1:0]          out_label0,
    output logic [XLEN-1:0]          out_label1,
    output logic [7:0]               out_class,
    output logic                     out_illegal,
    output logic [XLEN-1:0]          out_pc,
    output logic [15:0]              illegal_cnt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    decoded_t             dec;
    decoded_t             head;
    decoded_t             mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push;
    logic                 pop;

    instr_field_decode #(.XLEN(XLEN)) u_decode (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .dec_o   (dec)
    );

    // in_ready deliberately ignores out_ready so no combinational path crosses the stage.
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; head contents are meaningless until out_valid rises.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_opcode = head.opcode;
    assign out_func   = head.func;
    assign out_rs     = head.rs;
    assign out_rt     = head.rt;
    assign out_imm    = head.imm[XLEN-1:0];
    assign out_label0 = head.label0[XLEN-1:0];
    assign out_label1 = head.label1[XLEN-1:0];
    assign out_class  = head.cls;
    assign out_pc     = head.pc[XLEN-1:0];
    assign count      = count_q;

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (push && dec.illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_cnt_q <= '0;
        else     illegal_cnt_q <= illegal_cnt_d;
    end

    assign illegal_cnt = illegal_cnt_q;
    assign out_illegal = head.illegal;
`else
    assign illegal_cnt = '0;
    assign out_illegal = 1'b0;
`endif

endmodule
